instr_fetch: RTL and testbench
==============================

# instr_fetch

Program-counter and instruction-fetch unit that feeds the 9-bit machine code into the `control` decoder and consumes its `pc_jmp_en` / `pc_jmp_abs` / `LutPointer` outputs to pick the next PC. It is the other end of the decoder's branch interface: the decoder resolves the condition, and this block owns the PC register, the 16-entry jump-target LUT and the run/halt sequencing. It sits between instruction ROM (combinational read) and `control`.

## Interface
- `PC_W`, 10: PC and instruction-ROM address width
- `INSTR_W`, 9: machine-code width
- `LUT_DEPTH`, 16: jump LUT entries, indexed by the 4-bit `LutPointer`
- `clk`  in  1  clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins execution at PC 0
- `imem_addr`  out  PC_W  ROM address, always equal to `pc`
- `imem_data`  in  INSTR_W  combinational ROM read data
- `instr`  out  INSTR_W  instruction to `control`
- `pc_jmp_en`  in  1  from `control`: take branch this cycle
- `pc_jmp_abs`  in  1  from `control`: 1 = absolute target, 0 = PC-relative
- `lut_ptr`  in  4  from `control` `LutPointer`
- `lut_wr_en`  in  1  LUT load strobe
- `lut_wr_addr`  in  4  LUT load index
- `lut_wr_data`  in  PC_W  LUT load value: absolute target or two's-complement offset
- `pc`  out  PC_W  current program counter
- `done`  out  1  high while halted after executing HALT
- `cycle_cnt`  out  16  executed-instruction count of the current run

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: `instr` = 0 (decodes as cmp, no writes). Nothing advances. `start` moves to RUN with `pc` = 0 and `cycle_cnt` = 0.
- RUN: `instr` = `imem_data`, passed through combinationally, so the decoder and the branch result resolve in the same cycle.
- Next-PC priority in RUN:
  1. If `imem_data` == HALT_INSTR (9'h1FF), move to DONE. `pc` holds on the HALT address and the jump inputs are ignored.
  2. Else if `pc_jmp_en` and `pc_jmp_abs`, `pc` <= `lut[lut_ptr]`.
  3. Else if `pc_jmp_en`, `pc` <= `pc + lut[lut_ptr]`, modulo 2^PC_W. An offset of 0 is a self-loop.
  4. Else `pc` <= `pc + 1`, wrapping from 2^PC_W−1 to 0.
- `cycle_cnt` increments on every RUN cycle, including the HALT cycle, and saturates at 16'hFFFF.
- DONE: `done` = 1, `instr` = 0, `pc` and `cycle_cnt` are frozen. `start` restarts exactly as from IDLE.
- `start` in RUN is ignored.
- LUT writes are accepted in IDLE and DONE, and ignored in RUN. A write and a `start` in the same cycle are both applied; the write is visible from the first RUN cycle.

## Timing
- Reset values, applied asynchronously and immediately: state IDLE, `pc` 0, `cycle_cnt` 0, `done` 0, all LUT entries 0, `instr` 0.
- The LUT entries are reset too, so the LUT is flops, not RAM.
- Fetch-to-decode latency is 0 cycles, since ROM and decoder are combinational. A branch taken in cycle n fetches its target in cycle n+1.
- `done` rises on the clock edge that ends the HALT cycle and stays high until `start` or `reset`.
- Reset asserted mid-run aborts immediately. No partial state is retained, including LUT contents.
- `imem_addr` equals `pc` in every state.

## Structure
- Package `fetch_pkg`:
  - `PC_W`, `INSTR_W`, `HALT_INSTR`
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t`
- Sub-module `jump_lut`:
  - 16 × PC_W register file
  - asynchronous-reset write port, combinational read port indexed by `lut_ptr`
  - write gating done by its parent
- Top level holds the FSM, the PC next-state mux, the relative adder and the cycle counter.

## Test plan
- Reset, then `start`; ROM holds a nop at addresses 0–4 and HALT at 5 → `pc` steps 0,1,2,3,4,5. `done` rises after the addr-5 cycle, `cycle_cnt` = 6, `pc` holds at 5.
- LUT[3] = 10'h020 loaded in IDLE; at pc 4, drive `pc_jmp_en`=1, `pc_jmp_abs`=1, `lut_ptr`=3 → next `pc` = 0x020.
- LUT[2] = 10'h3FD (−3); relative jump at pc 0x010 → next `pc` = 0x00D. LUT[2] = 10'h005 at pc 0x3FE → next `pc` = 0x003 (wrap).
- HALT fetched while `pc_jmp_en`=1 → no jump, `done`=1, `pc` unchanged. A LUT write during RUN leaves the entry unchanged when read back after halt.
- `reset` asserted mid-run at pc 0x07 → outputs return to reset values asynchronously and LUT entries read 0. A later `start` runs from pc 0.
- 70000-instruction loop (relative offset 0 at a self-loop, then external `reset` is not used; HALT reached via a ROM swap) → `cycle_cnt` saturates at 16'hFFFF. `start` in DONE clears it to 0 and restarts at pc 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, HALT encoding and FSM state type for the instruction-fetch unit.
package fetch_pkg;
  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_AW    = 4;
  localparam int CNT_W     = 16;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/jump_lut.sv
// 16-entry jump-target register file: reset to zero, one write port, combinational read.
module jump_lut
  import fetch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [LUT_AW-1:0] wr_addr_i,
  input  logic [PC_W-1:0]   wr_data_i,
  input  logic [LUT_AW-1:0] rd_addr_i,
  output logic [PC_W-1:0]   rd_data_o
);
  logic [PC_W-1:0] mem_q [LUT_DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/instr_fetch.sv
// PC register, next-PC selection and IDLE/RUN/DONE sequencing in front of the
// combinational instruction ROM and the control decoder.
module instr_fetch
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  input  logic               pc_jmp_en,
  input  logic               pc_jmp_abs,
  input  logic [LUT_AW-1:0]  lut_ptr,
  input  logic               lut_wr_en,
  input  logic [LUT_AW-1:0]  lut_wr_addr,
  input  logic [PC_W-1:0]    lut_wr_data,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_cnt,
  output fetch_state_t       state_dbg
);
  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [PC_W-1:0]  lut_rd;
  logic             lut_we;
  logic             is_halt;

  // The LUT is frozen while running so branch targets stay stable mid-program.
  assign lut_we = lut_wr_en && (state_q != RUN);

  jump_lut u_lut (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (lut_we),
    .wr_addr_i (lut_wr_addr),
    .wr_data_i (lut_wr_data),
    .rd_addr_i (lut_ptr),
    .rd_data_o (lut_rd)
  );

  assign is_halt = (imem_data == HALT_INSTR);

  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (pc_jmp_en && pc_jmp_abs) pc_d = lut_rd;
    else if (pc_jmp_en)          pc_d = pc_q + lut_rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          cnt_q <= sat_inc(cnt_q);
          if (is_halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outside RUN the decoder sees 0, which decodes as a side-effect-free cmp.
  assign instr     = (state_q == RUN) ? imem_data : '0;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequencing, absolute/relative jumps, HALT
// priority, LUT write gating, asynchronous reset and counter saturation.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               pc_jmp_en;
  logic               pc_jmp_abs;
  logic [LUT_AW-1:0]  lut_ptr;
  logic               lut_wr_en;
  logic [LUT_AW-1:0]  lut_wr_addr;
  logic [PC_W-1:0]    lut_wr_data;
  logic [PC_W-1:0]    pc;
  logic               done;
  logic [CNT_W-1:0]   cycle_cnt;
  fetch_state_t       state_dbg;

  logic [INSTR_W-1:0] rom [0:1023];
  int tests = 0;
  int fails = 0;

  localparam logic [INSTR_W-1:0] NOP = 9'h055;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .pc_jmp_en   (pc_jmp_en),
    .pc_jmp_abs  (pc_jmp_abs),
    .lut_ptr     (lut_ptr),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .pc          (pc),
    .done        (done),
    .cycle_cnt   (cycle_cnt),
    .state_dbg   (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_pc(input string tag, input logic [PC_W-1:0] exp_pc,
                          input logic [CNT_W-1:0] exp_cnt);
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, "_addr"}, 32'(imem_addr), 32'(exp_pc));
    check({tag, "_cnt"}, 32'(cycle_cnt), 32'(exp_cnt));
  endtask

  task automatic jump(input logic abs, input logic [LUT_AW-1:0] ptr);
    pc_jmp_en  = 1'b1;
    pc_jmp_abs = abs;
    lut_ptr    = ptr;
  endtask

  task automatic no_jump();
    pc_jmp_en  = 1'b0;
    pc_jmp_abs = 1'b0;
    lut_ptr    = '0;
  endtask

  task automatic lut_write(input logic [LUT_AW-1:0] a, input logic [PC_W-1:0] d);
    lut_wr_en   = 1'b1;
    lut_wr_addr = a;
    lut_wr_data = d;
    tick();
    lut_wr_en   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = NOP;
    rom[5] = HALT_INSTR;
    reset = 1'b1; start = 1'b0;
    lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
    no_jump();

    // Reset state
    #12;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check_pc("rst", 10'h000, 16'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    reset = 1'b0;
    tick(); tick();
    check("idle_hold_pc", 32'(pc), 32'd0);
    check("idle_instr", 32'(instr), 32'd0);

    // Straight-line run 0..5, HALT at 5
    start = 1'b1; tick(); start = 1'b0;
    check("run_state", 32'(state_dbg), 32'(RUN));
    check("run_instr", 32'(instr), 32'(NOP));
    for (int i = 0; i < 5; i++) begin
      check_pc("seq", 10'(i), 16'(i));
      tick();
    end
    check_pc("seq_halt", 10'h005, 16'd5);
    check("seq_halt_done", 32'(done), 32'd0);
    tick();
    check_pc("seq_done", 10'h005, 16'd6);
    check("seq_done_done", 32'(done), 32'd1);
    check("seq_done_instr", 32'(instr), 32'd0);
    tick();
    check_pc("seq_frozen", 10'h005, 16'd6);

    // LUT loads in DONE; entry 7 written in the same cycle as start
    lut_write(4'd2, 10'h3FD);
    lut_write(4'd3, 10'h020);
    lut_write(4'd4, 10'h010);
    lut_write(4'd5, 10'h3FE);
    lut_write(4'd6, 10'h005);
    lut_wr_en = 1'b1; lut_wr_addr = 4'd7; lut_wr_data = 10'h007; start = 1'b1;
    tick();
    lut_wr_en = 1'b0; start = 1'b0;
    check_pc("restart", 10'h000, 16'd0);
    check("restart_done", 32'(done), 32'd0);
    tick(); tick(); tick(); tick();
    check_pc("at4", 10'h004, 16'd4);
    jump(1'b1, 4'd3); tick();
    check_pc("abs_020", 10'h020, 16'd5);
    jump(1'b1, 4'd4); tick();
    check_pc("abs_010", 10'h010, 16'd6);
    jump(1'b0, 4'd2); tick();
    check_pc("rel_neg3", 10'h00D, 16'd7);
    jump(1'b1, 4'd5); tick();
    check_pc("abs_3fe", 10'h3FE, 16'd8);
    jump(1'b0, 4'd6); tick();
    check_pc("rel_wrap", 10'h003, 16'd9);
    no_jump(); tick(); tick();
    check_pc("to_halt", 10'h005, 16'd11);
    // HALT wins over a pending jump; a LUT write while running is dropped
    jump(1'b1, 4'd3);
    lut_wr_en = 1'b1; lut_wr_addr = 4'd3; lut_wr_data = 10'h2AA;
    tick();
    lut_wr_en = 1'b0; no_jump();
    check_pc("halt_jmp", 10'h005, 16'd12);
    check("halt_jmp_done", 32'(done), 32'd1);

    // Read back LUT[3] and LUT[7] by jumping through them
    start = 1'b1; tick(); start = 1'b0;
    jump(1'b1, 4'd3); tick();
    check_pc("lut3_kept", 10'h020, 16'd1);
    jump(1'b1, 4'd7); tick();
    no_jump();
    check_pc("lut7_start_wr", 10'h007, 16'd2);

    // Asynchronous reset mid-run at pc 7
    #2 reset = 1'b1;
    #1;
    check("arst_state", 32'(state_dbg), 32'(IDLE));
    check_pc("arst", 10'h000, 16'd0);
    check("arst_instr", 32'(instr), 32'd0);
    reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check_pc("post_rst", 10'h000, 16'd0);
    jump(1'b1, 4'd3); tick();
    check_pc("lut_cleared", 10'h000, 16'd1);

    // Self-loop with relative offset 0 until the counter saturates
    jump(1'b0, 4'd0);
    for (int i = 0; i < 70000; i++) tick();
    check_pc("sat", 10'h000, 16'hFFFF);
    rom[0] = HALT_INSTR;
    #1;
    tick();
    check_pc("sat_halt", 10'h000, 16'hFFFF);
    check("sat_done", 32'(done), 32'd1);
    rom[0] = NOP;
    no_jump();
    start = 1'b1; tick(); start = 1'b0;
    check_pc("sat_restart", 10'h000, 16'd0);
    check("sat_restart_done", 32'(done), 32'd0);
    tick();
    check_pc("run_step", 10'h001, 16'd1);
    start = 1'b1; tick(); start = 1'b0;
    check_pc("start_in_run", 10'h002, 16'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
